// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller with a blocking miss FSM.
// Optional build macro DCACHE_STATS_EN adds saturating hit/miss counters (hit_cnt_o, miss_cnt_o).
module dcache_ctrl #(
    parameter int unsigned SETS       = 16,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [31:0]              p_addr_i,
    input  logic [31:0]              p_data_i,
    input  logic                     p_memRead_i,
    input  logic                     p_memWrite_i,
    output logic [31:0]              p_data_o,
    output logic                     p_stall_o,
    output logic [31:0]              mem_addr_o,
    output logic [32*LINE_WORDS-1:0] mem_data_o,
    input  logic [32*LINE_WORDS-1:0] mem_data_i,
    output logic                     mem_enable_o,
    output logic                     mem_write_o,
    input  logic                     mem_ack_i
`ifdef DCACHE_STATS_EN
    ,
    output logic [15:0]              hit_cnt_o,
    output logic [15:0]              miss_cnt_o
`endif
);
    localparam int unsigned LINE_BITS = 32 * LINE_WORDS;

    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;

    state_t                 state, state_next;
    logic [SETS-1:0]        valid, dirty;
    logic [23:0]            tag_mem  [SETS];
    logic [LINE_BITS-1:0]   data_mem [SETS];
    logic [27:0]            miss_line;

    logic [23:0]            req_tag;
    logic [3:0]             req_idx;
    logic [1:0]             req_word;
    logic [LINE_BITS-1:0]   req_line;
    logic [3:0]             miss_idx;
    logic [23:0]            miss_tag;
    logic                   req, hit, wr_hit, refill;
    logic                   addr_unused;

    assign req_tag     = p_addr_i[31:8];
    assign req_idx     = p_addr_i[7:4];
    assign req_word    = p_addr_i[3:2];
    assign addr_unused = ^p_addr_i[1:0];
    assign req_line    = data_mem[req_idx];
    assign miss_idx    = miss_line[3:0];
    assign miss_tag    = miss_line[27:4];

    assign req    = p_memRead_i | p_memWrite_i;
    assign hit    = req & valid[req_idx] & (tag_mem[req_idx] == req_tag);
    assign wr_hit = (state == IDLE) & hit & p_memWrite_i;
    assign refill = (state == ALLOCATE) & mem_ack_i;

    always_comb begin
        state_next   = state;
        p_stall_o    = 1'b0;
        p_data_o     = '0;
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        unique case (state)
            IDLE: begin
                // rst_i gate keeps the stall low while reset is held with a request present
                if (rst_i && req) begin
                    if (hit) begin
                        if (!p_memWrite_i) p_data_o = req_line[{req_word, 5'b0} +: 32];
                    end else begin
                        p_stall_o  = 1'b1;
                        state_next = (valid[req_idx] && dirty[req_idx]) ? WRITEBACK : ALLOCATE;
                    end
                end
            end
            WRITEBACK: begin
                p_stall_o    = 1'b1;
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = {tag_mem[miss_idx], miss_idx, 4'b0};
                mem_data_o   = data_mem[miss_idx];
                if (mem_ack_i) state_next = ALLOCATE;
            end
            ALLOCATE: begin
                p_stall_o    = 1'b1;
                mem_enable_o = 1'b1;
                mem_addr_o   = {miss_line, 4'b0};
                if (mem_ack_i) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state     <= IDLE;
            miss_line <= '0;
            valid     <= '0;
            dirty     <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && req && !hit) miss_line <= p_addr_i[31:4];
            if (wr_hit) dirty[req_idx] <= 1'b1;
            if (refill) begin
                valid[miss_idx] <= 1'b1;
                dirty[miss_idx] <= 1'b0;
            end
        end
    end

    // Tag/data arrays carry no reset; valid bits gate every use.
    always_ff @(posedge clk_i) begin
        if (wr_hit) data_mem[req_idx][{req_word, 5'b0} +: 32] <= p_data_i;
        if (refill) begin
            data_mem[miss_idx] <= mem_data_i;
            tag_mem[miss_idx]  <= miss_tag;
        end
    end

`ifdef DCACHE_STATS_EN
    logic retry;

    // The first IDLE cycle after a refill replays the missed access; it is not a new hit.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            retry      <= 1'b0;
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
        end else begin
            retry <= refill;
            if (state == IDLE && hit && !retry && hit_cnt_o != '1)
                hit_cnt_o <= hit_cnt_o + 16'd1;
            if (state == IDLE && req && !hit && miss_cnt_o != '1)
                miss_cnt_o <= miss_cnt_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: a set/line reference model predicts load data, stall
// length, memory transactions and counters; monitors compare as the DUT completes them.
`timescale 1ns/1ps
module tb_dcache_ctrl;
    localparam int unsigned TO_CYCLES = 200;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [31:0]  p_addr, p_wdata, p_rdata;
    logic         p_rd, p_wr, p_stall;
    logic [31:0]  mem_addr;
    logic [127:0] mem_wdata, mem_rdata;
    logic         mem_en, mem_we, mem_ack;
`ifdef DCACHE_STATS_EN
    logic [15:0]  hit_cnt, miss_cnt;
`endif

    dcache_ctrl #(.SETS(16), .LINE_WORDS(4)) dut (
        .clk_i        (clk),
        .rst_i        (rst_n),
        .p_addr_i     (p_addr),
        .p_data_i     (p_wdata),
        .p_memRead_i  (p_rd),
        .p_memWrite_i (p_wr),
        .p_data_o     (p_rdata),
        .p_stall_o    (p_stall),
        .mem_addr_o   (mem_addr),
        .mem_data_o   (mem_wdata),
        .mem_data_i   (mem_rdata),
        .mem_enable_o (mem_en),
        .mem_write_o  (mem_we),
        .mem_ack_i    (mem_ack)
`ifdef DCACHE_STATS_EN
        ,
        .hit_cnt_o    (hit_cnt),
        .miss_cnt_o   (miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [31:0] data; logic [31:0] stall; } acc_exp_t;
    typedef struct packed { logic wr; logic [31:0] addr; logic [127:0] line; } mem_exp_t;

    acc_exp_t     acc_q[$];
    mem_exp_t     mem_q[$];
    int unsigned  n_checks = 0;
    int unsigned  n_pass = 0;
    int unsigned  lat = 10;

    // Reference model: cache contents and backing memory as plain arrays.
    logic         m_valid [16];
    logic         m_dirty [16];
    logic [23:0]  m_tag   [16];
    logic [127:0] m_line  [16];
    logic [127:0] ref_mem [logic [31:0]];
    logic [127:0] sim_mem [logic [31:0]];
    int unsigned  m_hits, m_misses;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [127:0] line_init(input logic [31:0] a);
        logic [31:0] b = {a[31:4], 4'b0};
        return {b ^ 32'hA5A5_0003, b ^ 32'hA5A5_0002, b ^ 32'hA5A5_0001, b ^ 32'hA5A5_0000};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        m_hits   = 0;
        m_misses = 0;
    endtask

    task automatic predict(input logic wr, input logic [31:0] a, input logic [31:0] d);
        logic [3:0]  idx = a[7:4];
        logic [23:0] tag = a[31:8];
        logic [1:0]  w   = a[3:2];
        logic [31:0] la  = {a[31:4], 4'b0};
        logic [31:0] va;
        logic        wb  = 1'b0;
        logic [31:0] stall = 0;
        logic [31:0] data  = 0;
        if (m_valid[idx] && m_tag[idx] == tag) begin
            if (m_hits != 65535) m_hits++;
        end else begin
            if (m_misses != 65535) m_misses++;
            if (m_valid[idx] && m_dirty[idx]) begin
                wb = 1'b1;
                va = {m_tag[idx], idx, 4'b0};
                mem_q.push_back('{wr: 1'b1, addr: va, line: m_line[idx]});
                ref_mem[va] = m_line[idx];
            end
            mem_q.push_back('{wr: 1'b0, addr: la, line: 128'b0});
            m_line[idx]  = ref_mem.exists(la) ? ref_mem[la] : line_init(la);
            m_valid[idx] = 1'b1;
            m_dirty[idx] = 1'b0;
            m_tag[idx]   = tag;
            stall = 32'(1 + (lat + 1) * (wb ? 2 : 1));
        end
        if (wr) begin
            m_line[idx][{w, 5'b0} +: 32] = d;
            m_dirty[idx] = 1'b1;
        end else begin
            data = m_line[idx][{w, 5'b0} +: 32];
        end
        acc_q.push_back('{data: data, stall: stall});
    endtask

    task automatic do_access(input logic rd, input logic wr, input logic [31:0] a,
                             input logic [31:0] d);
        predict(wr, a, d);
        @(posedge clk); #1;
        p_rd = rd; p_wr = wr; p_addr = a; p_wdata = d;
        for (int c = 0; ; c++) begin
            @(negedge clk);
            if (!p_stall) break;
            if (c >= TO_CYCLES) begin
                check("access_timeout", 128'(p_stall), 128'(0));
                break;
            end
        end
    endtask

    task automatic idle();
        @(posedge clk); #1;
        p_rd = 1'b0; p_wr = 1'b0;
    endtask

    task automatic check_counters();
`ifdef DCACHE_STATS_EN
        @(negedge clk);
        check("hit_cnt", 128'(hit_cnt), 128'(m_hits));
        check("miss_cnt", 128'(miss_cnt), 128'(m_misses));
`endif
    endtask

    task automatic reset_abandon();
        @(posedge clk); #1;
        p_rd = 1'b1; p_wr = 1'b0; p_addr = 32'h40;
        repeat (3) @(posedge clk);
        #2;
        check("alloc_enable", 128'(mem_en), 128'(1));
        check("alloc_dir", 128'(mem_we), 128'(0));
        check("alloc_addr", 128'(mem_addr), 128'(32'h40));
        rst_n = 1'b0;
        #1;
        check("rst_mem_enable", 128'(mem_en), 128'(0));
        check("rst_stall", 128'(p_stall), 128'(0));
        check("rst_data", 128'(p_rdata), 128'(0));
        model_reset();
        check_counters();
        @(posedge clk); #1;
        p_rd = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin : mem_model
        int unsigned cnt = 0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            mem_ack = 1'b0;
            if (!mem_en) cnt = 0;
            else begin
                cnt++;
                if (cnt > lat) begin
                    mem_ack = 1'b1;
                    cnt = 0;
                    if (mem_we) sim_mem[mem_addr] = mem_wdata;
                    else mem_rdata = sim_mem.exists(mem_addr) ? sim_mem[mem_addr] : line_init(mem_addr);
                end
            end
        end
    end

    initial begin : acc_monitor
        int unsigned stall_cnt = 0;
        acc_exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) stall_cnt = 0;
            else if (p_rd || p_wr) begin
                if (p_stall) stall_cnt++;
                else if (acc_q.size() == 0) check("acc_unexpected", 128'(acc_q.size()), 128'(1));
                else begin
                    e = acc_q.pop_front();
                    check("load_data", 128'(p_rdata), 128'(e.data));
                    check("stall_cycles", 128'(stall_cnt), 128'(e.stall));
                    stall_cnt = 0;
                end
            end
        end
    end

    initial begin : mem_monitor
        logic        prev_en = 1'b0, prev_ack = 1'b0, prev_we = 1'b0;
        logic [31:0] prev_addr = '0;
        mem_exp_t    e;
        forever begin
            @(negedge clk);
            if (!rst_n) prev_en = 1'b0;
            else begin
                if (mem_en && prev_en && !prev_ack)
                    check("mem_addr_stable", 128'(mem_addr), 128'(prev_addr));
                if (prev_en && prev_ack && !prev_we)
                    check("mem_enable_drop", 128'(mem_en), 128'(0));
                if (mem_en && mem_ack) begin
                    if (mem_q.size() == 0) check("mem_unexpected", 128'(mem_q.size()), 128'(1));
                    else begin
                        e = mem_q.pop_front();
                        check("mem_write", 128'(mem_we), 128'(e.wr));
                        check("mem_addr", 128'(mem_addr), 128'(e.addr));
                        if (e.wr) check("wb_line", mem_wdata, e.line);
                    end
                end
                prev_en = mem_en; prev_ack = mem_ack; prev_we = mem_we; prev_addr = mem_addr;
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected completion within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [31:0] a;
        int unsigned op;
        p_rd = 1'b1; p_wr = 1'b0; p_addr = 32'h40; p_wdata = '0;
        model_reset();
        ref_mem[32'h40] = {32'hD, 32'hC, 32'hB, 32'hA};
        sim_mem[32'h40] = {32'hD, 32'hC, 32'hB, 32'hA};
        repeat (2) @(negedge clk);
        check("reset_stall", 128'(p_stall), 128'(0));
        check("reset_mem_enable", 128'(mem_en), 128'(0));
        check("reset_mem_write", 128'(mem_we), 128'(0));
        check("reset_data", 128'(p_rdata), 128'(0));
        check_counters();
        @(posedge clk); #1;
        p_rd = 1'b0;
        rst_n = 1'b1;

        lat = 10;
        do_access(1'b1, 1'b0, 32'h40, 32'h0);
        do_access(1'b0, 1'b1, 32'h44, 32'h1234_5678);
        do_access(1'b1, 1'b0, 32'h44, 32'h0);
        do_access(1'b1, 1'b0, 32'h1044, 32'h0);
        idle();
        check_counters();
        reset_abandon();
        do_access(1'b1, 1'b0, 32'h40, 32'h0);
        do_access(1'b1, 1'b1, 32'h48, 32'h5);
        do_access(1'b1, 1'b0, 32'h48, 32'h0);
        idle();
        check_counters();

        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 0) lat = $urandom_range(0, 4);
            op = $urandom_range(0, 3);
            a = $urandom;
            a[31:10] = '0;
            if ($urandom_range(0, 7) == 0) a[31:24] = 8'($urandom);
            if (op == 0) begin
                @(posedge clk); #1;
                p_rd = 1'b0; p_wr = 1'b0; p_addr = a;
                @(negedge clk);
                check("noop_stall", 128'(p_stall), 128'(0));
                check("noop_data", 128'(p_rdata), 128'(0));
            end else begin
                do_access(op != 2, op != 1, a, $urandom);
            end
        end
        idle();
        check_counters();

`ifdef DCACHE_STATS_EN
        for (int i = 0; i < 65540; i++) do_access(1'b1, 1'b0, 32'h40, 32'h0);
        idle();
        check_counters();
        do_access(1'b1, 1'b0, 32'h2040, 32'h0);
        idle();
        check_counters();
`endif

        for (int i = 0; i < 20 && (acc_q.size() != 0 || mem_q.size() != 0); i++) @(negedge clk);
        check("acc_queue_drained", 128'(acc_q.size()), 128'(0));
        check("mem_queue_drained", 128'(mem_q.size()), 128'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/dcache_ctrl.md
DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 SHALL have parameter: SETS, 16, number of direct-mapped lines (index = log2(SETS) bits, fixed at 4 here).
REQ-002 SHALL have parameter: LINE_WORDS, 4, 32-bit words per line (128-bit line, offset = addr[3:2]).
REQ-003 SHALL have ports: clk_i  in  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have ports: rst_i  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports: p_addr_i  in  32  CPU MEM-stage byte address (ALU result); [1:0] ignored.
REQ-006 SHALL have ports: p_data_i  in  32  CPU store data.
REQ-007 SHALL have ports: p_memRead_i / p_memWrite_i  in  1 each  load / store request.
REQ-008 SHALL have ports: p_data_o  out  32  load data; p_stall_o  out  1  freeze pipeline (PC, IF_ID, ID_EX, EX_MEM, MEM_WB).
REQ-009 SHALL have ports: mem_addr_o  out  32  line-aligned address; mem_data_o  out  128  writeback line; mem_data_i  in  128  refill line.
REQ-010 SHALL have ports: mem_enable_o, mem_write_o  out  1  memory request/direction; mem_ack_i  in  1  one-cycle completion pulse.
REQ-011 SHALL have ports (DCACHE_STATS_EN only): hit_cnt_o, miss_cnt_o  out  16  access counters.

Function
REQ-012 SHALL split address: tag = [31:8] (24 b), index = [7:4], word = [3:2]; per line store valid, dirty, tag, 128-bit data.
REQ-013 SHALL define hit = request & valid[index] & tag match, computed combinationally.
REQ-014 SHALL return read-hit word on p_data_o in same cycle, p_stall_o = 0; p_data_o = 0 when no read hit.
REQ-015 SHALL on write hit update only addressed word and set dirty at next rising edge, p_stall_o = 0.
REQ-016 SHALL give p_memWrite_i priority when both request bits set (access treated as store).
REQ-017 SHALL assert p_stall_o combinationally whenever a request misses in IDLE or state != IDLE.
REQ-018 SHALL implement FSM IDLE, WRITEBACK, ALLOCATE: IDLE->WRITEBACK on miss & victim dirty; IDLE->ALLOCATE on miss & victim clean.
REQ-019 SHALL in WRITEBACK drive mem_enable_o = 1, mem_write_o = 1, mem_addr_o = {victim tag, index, 4'b0}, mem_data_o = victim line; on mem_ack_i -> ALLOCATE.
REQ-020 SHALL in ALLOCATE drive mem_enable_o = 1, mem_write_o = 0, mem_addr_o = {req tag, index, 4'b0}; on mem_ack_i write mem_data_i into line, valid = 1, dirty = 0, tag = req tag, -> IDLE.
REQ-021 SHALL latch miss address at IDLE exit and use the latched value for all memory addresses, regardless of p_addr_i changes.
REQ-022 SHALL hold mem_enable_o and mem_addr_o stable until mem_ack_i, then deassert mem_enable_o in the following cycle.
REQ-023 SHALL complete the stalled access as a hit in the first IDLE cycle after refill, then drop p_stall_o (miss penalty = writeback + refill latency + 1 cycle).
REQ-024 SHALL ignore mem_ack_i in IDLE and ignore new requests while not IDLE.
REQ-025 SHALL treat no request (both bits 0) as no-op: no stall, no state change.

Reset
REQ-026 SHALL on rst_i low, immediately and regardless of state: FSM = IDLE, all valid/dirty = 0, mem_enable_o = 0, mem_write_o = 0, p_stall_o = 0, p_data_o = 0, counters = 0.
REQ-027 SHALL abandon an in-flight writeback/refill on reset without completing it; tag/data arrays need not be cleared.

Configuration
REQ-028 SHALL, with DCACHE_STATS_EN defined, provide hit_cnt_o/miss_cnt_o: each hit access +1, each miss +1 at IDLE exit (retry hit not counted), saturating at 16'hFFFF.
REQ-029 SHALL, without DCACHE_STATS_EN, omit both ports and all counter logic; all other behaviour identical.

Verification
REQ-030 SHALL cover: after reset, load 0x0000_0040, memory ack after 10 cycles with line {32'hD,32'hC,32'hB,32'hA} -> stall 12 cycles, p_data_o = 0xA, mem_write_o never 1.
REQ-031 SHALL cover: store 0x1234_5678 to 0x44 (hit on refilled line), then load 0x44 -> no stall, p_data_o = 0x1234_5678, dirty set.
REQ-032 SHALL cover: load 0x1044 (same index 4, new tag) -> WRITEBACK with mem_addr_o = 0x40, mem_data_o word1 = 0x1234_5678, then ALLOCATE mem_addr_o = 0x1040.
REQ-033 SHALL cover: rst_i low during ALLOCATE -> mem_enable_o and p_stall_o 0 asynchronously; next load 0x40 misses again.
REQ-034 SHALL cover: p_memRead_i and p_memWrite_i both 1, addr 0x48 hit, data 0x5 -> treated as store, subsequent load 0x48 returns 0x5.
REQ-035 SHALL cover (DCACHE_STATS_EN): sequence above -> miss_cnt_o and hit_cnt_o match counted accesses; forced 0xFFFF hits hold at 0xFFFF.
